// File: rtl/storage_banked_arb_pkg.sv
// Shared definitions for the banked management storage: macro geometry,
// RO requester encodings and the bank-field width helper.
package storage_banked_arb_pkg;

    localparam int SRAM_ROW_W  = 9;
    localparam int SRAM_DW     = 32;
    localparam int SRAM_MASK_W = 4;

    // RO requester identity; also the bit index of the matching grant.
    typedef enum logic {
        REQ_EXT  = 1'b0,
        REQ_MGMT = 1'b1
    } req_id_t;

    // A single bank still carries one bank bit, so that address 0x200 and up
    // decodes as out of range rather than aliasing onto bank 0.
    function automatic int bank_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/storage_banked_arb_if.sv
// RW and RO request/response bundle of the banked storage.
// The master drives requests, the slave (storage) answers.
interface storage_banked_arb_if
    import storage_banked_arb_pkg::*;
#(
    parameter int NUM_BANKS = 2
);
    localparam int ADDR_W = bank_w(NUM_BANKS) + SRAM_ROW_W;

    logic                   rw_valid;
    logic                   rw_we;
    logic [SRAM_MASK_W-1:0] rw_wmask;
    logic [ADDR_W-1:0]      rw_addr;
    logic [SRAM_DW-1:0]     rw_wdata;
    logic                   rw_rvalid;
    logic [SRAM_DW-1:0]     rw_rdata;
    logic                   rw_err;

    logic                   ro_mgmt_req;
    logic [ADDR_W-1:0]      ro_mgmt_addr;
    logic                   ro_mgmt_gnt;
    logic                   ro_mgmt_rvalid;
    logic                   ro_ext_req;
    logic [ADDR_W-1:0]      ro_ext_addr;
    logic                   ro_ext_gnt;
    logic                   ro_ext_rvalid;
    logic [SRAM_DW-1:0]     ro_rdata;

    modport master (
        output rw_valid, rw_we, rw_wmask, rw_addr, rw_wdata,
        output ro_mgmt_req, ro_mgmt_addr, ro_ext_req, ro_ext_addr,
        input  rw_rvalid, rw_rdata, rw_err,
        input  ro_mgmt_gnt, ro_mgmt_rvalid, ro_ext_gnt, ro_ext_rvalid, ro_rdata
    );

    modport slave (
        input  rw_valid, rw_we, rw_wmask, rw_addr, rw_wdata,
        input  ro_mgmt_req, ro_mgmt_addr, ro_ext_req, ro_ext_addr,
        output rw_rvalid, rw_rdata, rw_err,
        output ro_mgmt_gnt, ro_mgmt_rvalid, ro_ext_gnt, ro_ext_rvalid, ro_rdata
    );

endinterface

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// Behavioural stand-in for the 32x512 1RW/1R SRAM macro: active-low strobes,
// byte write mask, data out registered on the strobing edge.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [8:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [8:0]  addr1,
    output logic [31:0] dout1
);
    logic [31:0] mem [512];

    // RW port: masked byte writes, or a read into dout0.
    always_ff @(posedge clk0) begin
        if (!csb0 && !web0) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
            end
        end
        if (!csb0 && web0) dout0 <= mem[addr0];
    end

    // RO port: read into dout1.
    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= mem[addr1];
    end

endmodule

// File: rtl/storage_banked_arb_ro_arbiter.sv
// Two-way round-robin for the shared RO port. A write on the RW port to the
// exact word the RO winner wants suppresses both grants for that cycle, so the
// RO read lands after the write and returns the new data.
module storage_banked_arb_ro_arbiter
    import storage_banked_arb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_mgmt,
    input  logic              req_ext,
    input  logic [ADDR_W-1:0] addr_mgmt,
    input  logic [ADDR_W-1:0] addr_ext,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        gnt,
    output logic [ADDR_W-1:0] sel_addr,
    output req_id_t           owner
);
    req_id_t favour;
    logic    collide;

    // Pick the candidate: a lone requester wins, otherwise the favoured one.
    always_comb begin
        owner = REQ_EXT;
        if (req_mgmt && (!req_ext || favour == REQ_MGMT)) owner = REQ_MGMT;
        sel_addr = (owner == REQ_MGMT) ? addr_mgmt : addr_ext;
        collide  = wr_valid && (wr_addr == sel_addr);
        gnt[REQ_EXT]  = req_ext  && !collide && (owner == REQ_EXT);
        gnt[REQ_MGMT] = req_mgmt && !collide && (owner == REQ_MGMT);
    end

    // Favour the other requester after every grant; idle cycles leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour <= REQ_EXT;
        end else if (|gnt) begin
            favour <= (owner == REQ_EXT) ? REQ_MGMT : REQ_EXT;
        end
    end

endmodule

// File: rtl/storage_banked_arb.sv
// Banked management storage: NUM_BANKS SRAM macros behind a management RW port
// and a round-robin shared RO port. Word address = {bank, row}; every access
// returns two cycles after acceptance through registered outputs.
module storage_banked_arb
    import storage_banked_arb_pkg::*;
#(
    parameter int          NUM_BANKS = 2,
    parameter logic [31:0] ERR_DATA  = 32'h0
) (
    input logic                 mgmt_clk,
    input logic                 resetn,
    storage_banked_arb_if.slave bus
);
    localparam int BANK_W = bank_w(NUM_BANKS);
    localparam int ADDR_W = BANK_W + SRAM_ROW_W;

    logic [BANK_W-1:0]     rw_bank, ro_bank;
    logic [SRAM_ROW_W-1:0] rw_row, ro_row;
    logic                  rw_hit, ro_hit;
    logic [1:0]            gnt;
    logic [ADDR_W-1:0]     ro_addr;
    req_id_t               ro_owner;
    logic                  ro_accept;

    logic [SRAM_DW-1:0]    dout0 [NUM_BANKS];
    logic [SRAM_DW-1:0]    dout1 [NUM_BANKS];
    logic [SRAM_DW-1:0]    dout0_sel, dout1_sel;

    // First pipeline stage: what was strobed into the macros last edge.
    logic                  rw1_rd, rw1_err;
    logic [BANK_W-1:0]     rw1_bank;
    logic                  ro1_valid, ro1_err;
    req_id_t               ro1_owner;
    logic [BANK_W-1:0]     ro1_bank;

    assign rw_bank = bus.rw_addr[ADDR_W-1:SRAM_ROW_W];
    assign rw_row  = bus.rw_addr[SRAM_ROW_W-1:0];
    assign rw_hit  = int'(rw_bank) < NUM_BANKS;
    assign ro_bank = ro_addr[ADDR_W-1:SRAM_ROW_W];
    assign ro_row  = ro_addr[SRAM_ROW_W-1:0];
    assign ro_hit  = int'(ro_bank) < NUM_BANKS;

    storage_banked_arb_ro_arbiter #(.ADDR_W(ADDR_W)) u_arb (
        .clk       (mgmt_clk),
        .rst_n     (resetn),
        .req_mgmt  (bus.ro_mgmt_req),
        .req_ext   (bus.ro_ext_req),
        .addr_mgmt (bus.ro_mgmt_addr),
        .addr_ext  (bus.ro_ext_addr),
        .wr_valid  (bus.rw_valid & bus.rw_we),
        .wr_addr   (bus.rw_addr),
        .gnt       (gnt),
        .sel_addr  (ro_addr),
        .owner     (ro_owner)
    );

    assign bus.ro_ext_gnt  = gnt[REQ_EXT];
    assign bus.ro_mgmt_gnt = gnt[REQ_MGMT];
    assign ro_accept       = |gnt;

    // Strobes are gated with resetn so the macros stay deselected in reset.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sky130_sram_2kbyte_1rw1r_32x512_8 u_sram (
            .clk0   (mgmt_clk),
            .csb0   (~(resetn & bus.rw_valid & rw_hit & (rw_bank == BANK_W'(b)))),
            .web0   (~(resetn & bus.rw_we)),
            .wmask0 (bus.rw_wmask),
            .addr0  (rw_row),
            .din0   (bus.rw_wdata),
            .dout0  (dout0[b]),
            .clk1   (mgmt_clk),
            .csb1   (~(resetn & ro_accept & ro_hit & (ro_bank == BANK_W'(b)))),
            .addr1  (ro_row),
            .dout1  (dout1[b])
        );
    end

    // Route the macro outputs of the bank registered in stage one.
    always_comb begin
        dout0_sel = '0;
        dout1_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rw1_bank == BANK_W'(b)) dout0_sel = dout0[b];
            if (ro1_bank == BANK_W'(b)) dout1_sel = dout1[b];
        end
    end

    // Stage one tags, then registered responses; reset drops in-flight tags.
    always_ff @(posedge mgmt_clk or negedge resetn) begin
        if (!resetn) begin
            rw1_rd             <= 1'b0;
            rw1_err            <= 1'b0;
            rw1_bank           <= '0;
            ro1_valid          <= 1'b0;
            ro1_err            <= 1'b0;
            ro1_owner          <= REQ_EXT;
            ro1_bank           <= '0;
            bus.rw_rvalid      <= 1'b0;
            bus.rw_err         <= 1'b0;
            bus.rw_rdata       <= '0;
            bus.ro_mgmt_rvalid <= 1'b0;
            bus.ro_ext_rvalid  <= 1'b0;
            bus.ro_rdata       <= '0;
        end else begin
            rw1_rd    <= bus.rw_valid & ~bus.rw_we;
            rw1_err   <= bus.rw_valid & ~rw_hit;
            rw1_bank  <= rw_bank;
            ro1_valid <= ro_accept;
            ro1_err   <= ro_accept & ~ro_hit;
            ro1_owner <= ro_owner;
            ro1_bank  <= ro_bank;

            bus.rw_rvalid <= rw1_rd & ~rw1_err;
            bus.rw_err    <= rw1_err;
            if (rw1_rd && !rw1_err) bus.rw_rdata <= dout0_sel;

            bus.ro_mgmt_rvalid <= ro1_valid & (ro1_owner == REQ_MGMT);
            bus.ro_ext_rvalid  <= ro1_valid & (ro1_owner == REQ_EXT);
            if (ro1_valid) bus.ro_rdata <= ro1_err ? ERR_DATA : dout1_sel;
        end
    end

endmodule
